// File: rtl/dot_seq_pkg.sv
// Shared types and default sizing for the dot-product sequencer.
package dot_seq_pkg;

  localparam int unsigned ADDR_WIDTH_D   = 5;
  localparam int unsigned RESULT_WIDTH_D = 16;
  localparam int unsigned PIPE_LAT_D     = 3;

  // Wide enough to sum 2^aw - 1 partials of rw bits without overflow.
  function automatic int unsigned acc_width(input int unsigned rw, input int unsigned aw);
    return rw + aw;
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/dot_seq_delay.sv
// Fixed-depth 1-bit delay line with synchronous active-low clear.
module dot_seq_delay
  import dot_seq_pkg::*;
#(
  parameter int unsigned DEPTH = PIPE_LAT_D
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_din,
  output logic o_dout
);

  logic [DEPTH-1:0] r_line;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_line <= '0;
    end else begin
      r_line <= (r_line << 1) | DEPTH'(i_din);
    end
  end

  assign o_dout = r_line[DEPTH-1];

endmodule

// File: rtl/dot_product_sequencer.sv
// Streams address pairs to two RAMs, aligns the engine start pulse and
// accumulates per-word partials into a result returned over valid/ready.
module dot_product_sequencer
  import dot_seq_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_D,
  parameter int unsigned RESULT_WIDTH = RESULT_WIDTH_D,
  parameter int unsigned ACC_WIDTH    = acc_width(RESULT_WIDTH_D, ADDR_WIDTH_D),
  parameter int unsigned PIPE_LAT     = PIPE_LAT_D
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_cmd_valid,
  output logic                    o_cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   i_cmd_base1,
  input  logic [ADDR_WIDTH-1:0]   i_cmd_base2,
  input  logic [ADDR_WIDTH-1:0]   i_cmd_len,
  output logic                    o_mem_rd_en,
  output logic [ADDR_WIDTH-1:0]   o_mem1_addr,
  output logic [ADDR_WIDTH-1:0]   o_mem2_addr,
  output logic                    o_dp_start,
  input  logic [RESULT_WIDTH-1:0] i_dp_result,
  input  logic                    i_dp_done,
  output logic                    o_res_valid,
  input  logic                    i_res_ready,
  output logic [ACC_WIDTH-1:0]    o_res_data,
  output logic                    o_busy
);

  state_t                r_state,     w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr1,     w_addr1_nxt;
  logic [ADDR_WIDTH-1:0] r_addr2,     w_addr2_nxt;
  logic [ADDR_WIDTH-1:0] r_len,       w_len_nxt;
  logic [ADDR_WIDTH-1:0] r_issue_cnt, w_issue_cnt_nxt;
  logic [ADDR_WIDTH-1:0] r_done_cnt,  w_done_cnt_nxt;
  logic [ACC_WIDTH-1:0]  r_acc,       w_acc_nxt;
  logic                  r_mem_rd_en, w_mem_rd_en_nxt;
  logic                  r_cmd_ready, w_cmd_ready_nxt;
  logic                  r_res_valid, w_res_valid_nxt;
  logic                  r_busy,      w_busy_nxt;
  logic                  w_done_hit;
  logic                  w_dp_start;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_addr1     <= '0;
      r_addr2     <= '0;
      r_len       <= '0;
      r_issue_cnt <= '0;
      r_done_cnt  <= '0;
      r_acc       <= '0;
      r_mem_rd_en <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_addr1     <= w_addr1_nxt;
      r_addr2     <= w_addr2_nxt;
      r_len       <= w_len_nxt;
      r_issue_cnt <= w_issue_cnt_nxt;
      r_done_cnt  <= w_done_cnt_nxt;
      r_acc       <= w_acc_nxt;
      r_mem_rd_en <= w_mem_rd_en_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_res_valid <= w_res_valid_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_addr1_nxt     = r_addr1;
    w_addr2_nxt     = r_addr2;
    w_len_nxt       = r_len;
    w_issue_cnt_nxt = r_issue_cnt;
    w_done_cnt_nxt  = r_done_cnt;
    w_acc_nxt       = r_acc;
    w_mem_rd_en_nxt = 1'b0;

    // Only partials belonging to the active command are summed.
    w_done_hit = ((r_state == ISSUE) || (r_state == DRAIN)) && i_dp_done &&
                 (r_done_cnt < r_len);
    if (w_done_hit) begin
      w_acc_nxt      = r_acc + ACC_WIDTH'(i_dp_result);
      w_done_cnt_nxt = r_done_cnt + ADDR_WIDTH'(1);
    end

    case (r_state)
      IDLE: begin
        if (i_cmd_valid && r_cmd_ready) begin
          w_len_nxt      = i_cmd_len;
          w_acc_nxt      = '0;
          w_done_cnt_nxt = '0;
          w_addr1_nxt    = i_cmd_base1;
          w_addr2_nxt    = i_cmd_base2;
          if (i_cmd_len == '0) begin
            w_issue_cnt_nxt = '0;
            w_state_nxt     = DONE;
          end else begin
            w_issue_cnt_nxt = ADDR_WIDTH'(1);
            w_mem_rd_en_nxt = 1'b1;
            w_state_nxt     = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (r_issue_cnt == r_len) begin
          w_state_nxt = DRAIN;
        end else begin
          w_mem_rd_en_nxt = 1'b1;
          w_addr1_nxt     = r_addr1 + ADDR_WIDTH'(1);
          w_addr2_nxt     = r_addr2 + ADDR_WIDTH'(1);
          w_issue_cnt_nxt = r_issue_cnt + ADDR_WIDTH'(1);
        end
      end
      DRAIN: begin
        // Look at the post-update count so res_valid rises right after the last partial.
        if (w_done_cnt_nxt == r_len) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (i_res_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    w_cmd_ready_nxt = (w_state_nxt == IDLE);
    w_busy_nxt      = (w_state_nxt != IDLE);
    w_res_valid_nxt = (w_state_nxt == DONE);
  end

  dot_seq_delay #(
    .DEPTH (PIPE_LAT)
  ) u_start_delay (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_din   (r_mem_rd_en),
    .o_dout  (w_dp_start)
  );

  assign o_cmd_ready = r_cmd_ready;
  assign o_mem_rd_en = r_mem_rd_en;
  assign o_mem1_addr = r_addr1;
  assign o_mem2_addr = r_addr2;
  assign o_dp_start  = w_dp_start;
  assign o_res_valid = r_res_valid;
  assign o_res_data  = r_acc;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Sequencer paired with two 1-cycle RAM models and a 4-lane dot-product engine model.
module tb_dot_product_sequencer;

  localparam int unsigned AW   = 5;
  localparam int unsigned RW   = 16;
  localparam int unsigned ACCW = 21;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [AW-1:0]   cmd_base1, cmd_base2, cmd_len;
  logic            mem_rd_en;
  logic [AW-1:0]   mem1_addr, mem2_addr;
  logic            dp_start;
  logic            res_valid;
  logic            res_ready;
  logic [ACCW-1:0] res_data;
  logic            busy;

  logic [31:0] mem1 [32];
  logic [31:0] mem2 [32];
  logic [31:0] rd1, rd2, e1a, e1b, e2a, e2b;
  logic [RW-1:0] eng_res;
  logic          eng_done;

  int cyc = 0;
  int t0 = 0;
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];
  logic [AW-1:0] a1_q [$];
  logic [AW-1:0] a2_q [$];
  int st_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  dot_product_sequencer dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_cmd_base1 (cmd_base1),
    .i_cmd_base2 (cmd_base2),
    .i_cmd_len   (cmd_len),
    .o_mem_rd_en (mem_rd_en),
    .o_mem1_addr (mem1_addr),
    .o_mem2_addr (mem2_addr),
    .o_dp_start  (dp_start),
    .i_dp_result (eng_res),
    .i_dp_done   (eng_done),
    .o_res_valid (res_valid),
    .i_res_ready (res_ready),
    .o_res_data  (res_data),
    .o_busy      (busy)
  );

  function automatic logic [15:0] dot4(input logic [31:0] a, input logic [31:0] b);
    logic [17:0] s;
    s = '0;
    for (int i = 0; i < 4; i++) s += 18'(a[8*i +: 8]) * 18'(b[8*i +: 8]);
    return s[15:0];
  endfunction

  // RAMs: one cycle read latency.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      rd1 <= mem1[mem1_addr];
      rd2 <= mem2[mem2_addr];
    end
  end

  // Engine: two input register stages, then a registered result with done.
  always @(posedge clk) begin
    if (!rst_n) begin
      e1a <= '0; e1b <= '0; e2a <= '0; e2b <= '0;
      eng_res <= '0; eng_done <= 1'b0;
    end else begin
      e1a <= rd1; e1b <= rd2; e2a <= e1a; e2b <= e1b;
      eng_done <= dp_start;
      if (dp_start) eng_res <= dot4(e2a, e2b);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor and scoreboard.
  always @(negedge clk) begin
    if (mem_rd_en) begin
      a1_q.push_back(mem1_addr);
      a2_q.push_back(mem2_addr);
    end
    if (dp_start) st_q.push_back(cyc - t0);
    if (res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got result 0x%0h with nothing expected", res_data);
      end else begin
        chk("sb_res_data", 64'(res_data), 64'(exp_q.pop_front()));
      end
    end
  end

  // Entered and left just after a rising edge.
  task automatic run_cmd(input string nm, input logic [AW-1:0] b1, input logic [AW-1:0] b2,
                         input logic [AW-1:0] len, input logic [31:0] exp_data,
                         input int exp_v, input int hold, output int t0_o, output int hs_o);
    bit got;
    int bad;
    logic [ACCW-1:0] held;
    a1_q.delete(); a2_q.delete(); st_q.delete();
    exp_q.push_back(exp_data);
    cmd_valid = 1'b1; cmd_base1 = b1; cmd_base2 = b2; cmd_len = len;
    got = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cmd_ready) begin got = 1; break; end
    end
    t0 = cyc;
    t0_o = cyc;
    chk({nm, "_cmd_accepted"}, 64'(got), 64'(1));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    got = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (res_valid) begin got = 1; break; end
    end
    if (!got) begin
      chk({nm, "_res_valid_timeout"}, 64'(0), 64'(1));
      exp_q.delete();
      hs_o = cyc;
      @(posedge clk); #1;
      return;
    end
    chk({nm, "_valid_cycle"}, 64'(cyc - t0), 64'(exp_v));
    chk({nm, "_busy_ready_in_done"}, 64'({busy, cmd_ready}), 64'(2'b10));
    held = res_data;
    bad = 0;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (res_data !== held || cmd_ready !== 1'b0 || res_valid !== 1'b1) bad++;
    end
    if (hold > 0) chk({nm, "_hold_stable_bad"}, 64'(bad), 64'(0));
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    res_ready = 1'b0;
    hs_o = cyc - 1;
    chk({nm, "_addr_cnt"}, 64'(a1_q.size()), 64'(len));
    bad = 0;
    for (int i = 0; i < a1_q.size(); i++) begin
      if (a1_q[i] !== AW'(b1 + i)) bad++;
      if (a2_q[i] !== AW'(b2 + i)) bad++;
    end
    chk({nm, "_addr_bad"}, 64'(bad), 64'(0));
    chk({nm, "_start_cnt"}, 64'(st_q.size()), 64'(len));
    if (len != 0 && st_q.size() != 0) begin
      chk({nm, "_start_first"}, 64'(st_q[0]), 64'(4));
      chk({nm, "_start_last"}, 64'(st_q[st_q.size()-1]), 64'(len + 3));
    end
  endtask

  initial begin
    int ta, ha, tb_, hb;
    rst_n = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
    cmd_base1 = '0; cmd_base2 = '0; cmd_len = '0;
    for (int i = 0; i < 32; i++) begin mem1[i] = '0; mem2[i] = '0; end
    for (int i = 0; i < 4; i++) begin mem1[i] = 32'h0101_0101; mem2[i] = 32'h0202_0202; end

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_outputs", 64'({cmd_ready, mem_rd_en, mem1_addr, mem2_addr, dp_start,
                              res_valid, res_data, busy}), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_reset_ready_busy", 64'({cmd_ready, busy}), 64'(2'b10));
    @(posedge clk); #1;

    run_cmd("basic",  5'd0, 5'd0, 5'd4, 32'd32, 9, 0, ta, ha);
    run_cmd("single", 5'd0, 5'd0, 5'd1, 32'd8,  6, 0, ta, ha);
    run_cmd("zero",   5'd0, 5'd0, 5'd0, 32'd0,  1, 0, ta, ha);
    run_cmd("bp",     5'd0, 5'd0, 5'd4, 32'd32, 9, 10, ta, ha);
    run_cmd("b2b",    5'd0, 5'd0, 5'd2, 32'd16, 7, 0, tb_, hb);
    chk("b2b_accept_cycle", 64'(tb_), 64'(ha + 1));

    mem1[30] = 32'h0102_0304; mem1[31] = 32'h0102_0304;
    mem1[0]  = 32'h0102_0304; mem1[1]  = 32'h0102_0304;
    mem2[30] = 32'h0101_0101; mem2[31] = 32'h0101_0101;
    mem2[0]  = 32'h0101_0101; mem2[1]  = 32'h0101_0101;
    run_cmd("wrap", 5'd30, 5'd30, 5'd4, 32'd40, 9, 0, ta, ha);

    // Reset in cycle 3 of a len=8 run.
    cmd_valid = 1'b1; cmd_base1 = 5'd0; cmd_base2 = 5'd0; cmd_len = 5'd8;
    begin
      bit got;
      got = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (cmd_ready) begin got = 1; break; end
      end
      t0 = cyc;
      chk("rstmid_cmd_accepted", 64'(got), 64'(1));
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    st_q.delete();
    @(negedge clk);
    chk("rstmid_outputs", 64'({cmd_ready, mem_rd_en, mem1_addr, mem2_addr, dp_start,
                               res_valid, res_data, busy}), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (14) @(posedge clk);
    #1;
    chk("rstmid_no_start", 64'(st_q.size()), 64'(0));
    chk("rstmid_ready", 64'(cmd_ready), 64'(1));
    run_cmd("after_rst", 5'd2, 5'd2, 5'd2, 32'd16, 7, 0, ta, ha);

    repeat (3) @(posedge clk);
    chk("sb_drained", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dot_product_sequencer.md
# dot_product_sequencer

Command-driven controller that sequences the 4-lane dot-product engine over multi-word vectors held in two synchronous RAMs. It accepts a command (two base addresses and a length), streams one address pair per cycle to both RAMs, and pulses the engine's `start_processing` aligned to the engine pipeline. It accumulates each per-word partial result into a wide accumulator and returns the total over a valid/ready result handshake. It sits between the command source and the RAM-plus-engine datapath; RAM read data feeds the engine's `mem1_input`/`mem2_input` directly and does not pass through this block.

## Interface
- `ADDR_WIDTH`, 5: RAM address width; also the width of the length field.
- `RESULT_WIDTH`, 16: width of the engine's `dot_product_result`.
- `ACC_WIDTH`, `RESULT_WIDTH+ADDR_WIDTH` (21): accumulator and result width; sized so it cannot overflow.
- `PIPE_LAT`, 3: cycles from an address issue to the matching `dp_start` (1 RAM read + 2 engine register stages).

- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_base1`  in  ADDR_WIDTH  start address of vector 1.
- `cmd_base2`  in  ADDR_WIDTH  start address of vector 2.
- `cmd_len`  in  ADDR_WIDTH  number of 32-bit words per vector; 0 is legal.
- `mem_rd_en`  out  1  read strobe, shared by both RAMs.
- `mem1_addr`  out  ADDR_WIDTH  RAM1 address.
- `mem2_addr`  out  ADDR_WIDTH  RAM2 address.
- `dp_start`  out  1  drives the engine's `start_processing`.
- `dp_result`  in  RESULT_WIDTH  engine's `dot_product_result`.
- `dp_done`  in  1  engine's `processing_done`.
- `res_valid`  out  1  accumulated result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_data`  out  ACC_WIDTH  accumulated dot product.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states:
  - IDLE: `cmd_ready`=1. On `cmd_valid`, latch the bases and length, clear the accumulator and both counters. Go to DONE if `cmd_len`==0, otherwise go to ISSUE.
  - ISSUE: `mem_rd_en`=1 every cycle. Addresses are base+i for i=0..len-1. After the len-th issue, go to DRAIN.
  - DRAIN: `mem_rd_en`=0. Wait until the done counter reaches len.
  - DONE: `res_valid`=1 and `res_data` holds the accumulator. On `res_ready`, go to IDLE.
- Addresses wrap modulo 2^ADDR_WIDTH. For example, base 30 with len 4 issues addresses 30, 31, 0, 1.
- `dp_start` is `mem_rd_en` delayed by exactly PIPE_LAT cycles through a shift register that resets to 0.
- On each `dp_done` while in ISSUE or DRAIN with done count < len:
  - acc <= acc + zero-extended `dp_result`
  - done count increments
- `dp_done` in IDLE or DONE, or beyond len pulses, is ignored.
- Engine-side truncation of the partial sum is not corrected here; the block accumulates `dp_result` exactly as received.
- `res_data` is stable while `res_valid` is high and `res_ready` is low.

## Timing
- Cycle 0: command handshake.
- Cycles 1..len: `mem_rd_en` high.
- Cycles 4..len+3: `dp_start` high.
- Cycles 5..len+4: `dp_done` high (engine behaviour).
- Cycle len+5: first cycle with `res_valid` high.
- len=0: `res_valid` high in cycle 1.
- Throughput is one word per cycle. The next command is accepted no earlier than the cycle after the result handshake.
- All outputs are registered.
- Reset values: `cmd_ready`=0 in the reset cycle and 1 from the first cycle after reset deasserts. All other outputs are 0: `mem_rd_en`, `mem1_addr`, `mem2_addr`, `dp_start`, `res_valid`, `res_data`, `busy`.
- Reset mid-operation: the FSM returns to IDLE, and the accumulator, counters and delay line are cleared. No `dp_start` is emitted after reset, even for issues already in flight.
- `cmd_valid` is ignored while `cmd_ready`=0.

## Structure
- Package `dot_seq_pkg` holds:
  - the state enum (IDLE, ISSUE, DRAIN, DONE)
  - the default constants for PIPE_LAT and the width derivation of ACC_WIDTH
- Sub-module `dot_seq_delay`: parameterised 1-bit shift line of depth PIPE_LAT with synchronous active-low clear. It produces `dp_start`.
- The top level holds the FSM, address and issue counters, the done counter and the accumulator.
- The bench pairs the block with two 1-cycle-latency RAM models and the dot-product engine.

## Test plan
- Basic run: mem1[0..3]=0x01010101, mem2[0..3]=0x02020202, base1=0, base2=0, len=4. Expect 4 partials of 8, `res_data`=32, `res_valid` first high in cycle 9.
- Single word: mem1[0..3] as above, mem2[0..3] as above, len=1, base1=base2=0. Expect `dp_start` only in cycle 4, `res_data`=8, `res_valid` in cycle 6.
- Wrap-around: mem1[30,31,0,1]=0x01020304, mem2[30,31,0,1]=0x01010101, base1=base2=30, len=4. Expect addresses 30, 31, 0, 1 in order and `res_data`=40.
- Zero length: len=0. Expect no `mem_rd_en`, no `dp_start`, `res_data`=0 with `res_valid` in cycle 1.
- Backpressure and back-to-back: hold `res_ready`=0 for 10 cycles. Expect `res_data` stable and `cmd_ready`=0 throughout. After the handshake, a second command is accepted on the next cycle.
- Reset mid-run: assert `rst_n`=0 in cycle 3 of a len=8 run. Expect all outputs zeroed, no `dp_start` afterwards, and a subsequent len=2 command completing with the correct result.
